// File: rtl/gpu_core_param.sv
// Parametrised GPU compute core: loads a program burst from the task scheduler, runs it on a
// multi-cycle F/D/E/M/WB sequencer over a 16-entry register file, and accesses shared memory via req/ack.
module gpu_core_param #(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 12,
  parameter int CORE_ID    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              val_ins,
  input  logic              ins_last,
  input  logic [15:0]       instruction,
  output logic              rtr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              ready,
  output logic              div_err
);
  localparam int PW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [PW-1:0] IDX_MAX = PW'(IMEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MEM_WAIT, S_WB, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            idx_q, idx_d, pc_q, pc_d;
  logic [PW:0]              len_q, len_d;
  logic [15:0]              ir_q, ir_d;
  logic [DATA_W-1:0]        a_q, a_d, b_q, b_d, d_q, d_d, res_q, res_d;
  logic                     div_err_q, div_err_d, ready_q, ready_d;
  logic                     mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
  logic [15:0][DATA_W-1:0]  rf_q, rf_d;
  logic [15:0]              imem_q [IMEM_DEPTH];
  logic                     imem_we;

  logic [3:0]        op;
  logic              is_cid, taken, rf_wr;
  logic [3:0]        sh;
  logic [DATA_W-1:0] alu_res;
  logic [PW:0]       npc;

  assign op     = ir_q[15:12];
  assign is_cid = (ir_q[11:4] == 8'h01);
  assign sh     = b_q[3:0];
  assign taken  = (op == 4'd14) && (a_q != '0);
  assign rf_wr  = ((op >= 4'd1) && (op <= 4'd12)) || ((op == 4'd0) && is_cid);
  assign npc    = taken ? {1'b0, ir_q[PW+3:4]} : {1'b0, pc_q} + 1'b1;

  always_comb begin
    alu_res = '0;
    unique case (op)
      4'd0:    alu_res = DATA_W'(CORE_ID);
      4'd1:    alu_res = a_q + b_q;
      4'd2:    alu_res = a_q - b_q;
      4'd3:    alu_res = a_q * b_q;
      4'd4:    alu_res = (b_q == '0) ? '1 : a_q / b_q;
      4'd5:    alu_res = {{(DATA_W-1){1'b0}}, (a_q >= b_q)};
      4'd6:    alu_res = (int'(sh) >= DATA_W) ? '0 : a_q >> sh;
      4'd7:    alu_res = (int'(sh) >= DATA_W) ? '0 : a_q << sh;
      4'd8:    alu_res = a_q & b_q;
      4'd9:    alu_res = a_q | b_q;
      4'd10:   alu_res = a_q ^ b_q;
      4'd12:   alu_res = DATA_W'(ir_q[11:4]);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    d_d         = d_q;
    res_d       = res_q;
    div_err_d   = div_err_q;
    ready_d     = ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_d        = rf_q;
    imem_we     = 1'b0;
    unique case (state_q)
      S_LOAD: if (val_ins) begin
        imem_we = 1'b1;
        ready_d = 1'b0;
        idx_d   = idx_q + 1'b1;
        if (ins_last || (idx_q == IDX_MAX)) begin
          len_d     = {1'b0, idx_q} + 1'b1;
          idx_d     = '0;
          pc_d      = '0;
          div_err_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = imem_q[pc_q];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rf_q[ir_q[11:8]];
        b_d     = rf_q[ir_q[7:4]];
        d_d     = rf_q[ir_q[3:0]];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = alu_res;
        if ((op == 4'd4) && (b_q == '0)) div_err_d = 1'b1;
        state_d = S_MEM;
      end
      S_MEM: begin
        if ((op == 4'd11) || (op == 4'd13)) begin
          mem_req_d  = 1'b1;
          mem_we_d   = (op == 4'd13);
          mem_addr_d = ADDR_W'({b_q[3:0], a_q});
          if (op == 4'd13) mem_wdata_d = d_q;
          state_d    = S_MEM_WAIT;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_WAIT: if (mem_ack) begin
        mem_req_d = 1'b0;
        if (op == 4'd11) res_d = mem_rdata;
        state_d   = S_WB;
      end
      S_WB: begin
        if (rf_wr) rf_d[ir_q[3:0]] = res_q;
        if ((op == 4'd15) || (npc >= len_q)) begin
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          pc_d    = npc[PW-1:0];
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      len_q       <= '0;
      pc_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      res_q       <= '0;
      div_err_q   <= 1'b0;
      ready_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rf_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      d_q         <= d_d;
      res_q       <= res_d;
      div_err_q   <= div_err_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rf_q        <= rf_d;
    end
  end

  // Instruction store holds no reset; contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[idx_q] <= instruction;
  end

  assign rtr       = (state_q == S_LOAD) || (state_q == S_DONE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ready     = ready_q;
  assign div_err   = div_err_q;
endmodule

// File: tb/tb_gpu_core_param.sv
// Randomised bench for gpu_core_param: an instruction-level reference model predicts SM traffic,
// cycle counts and div_err; a shared-memory responder drives acks with random delay.
module tb_gpu_core_param;
  localparam int DW = 8, DEPTH = 16, AW = 12, CID = 4;

  logic          clk = 0, reset_n = 0, val_ins = 0, ins_last = 0, mem_ack = 0;
  logic [15:0]   instruction = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          rtr, mem_req, mem_we, ready, div_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  gpu_core_param #(.DATA_W(DW), .IMEM_DEPTH(DEPTH), .ADDR_W(AW), .CORE_ID(CID)) dut (
    .clk(clk), .reset_n(reset_n), .val_ins(val_ins), .ins_last(ins_last),
    .instruction(instruction), .rtr(rtr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .ready(ready), .div_err(div_err));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int            ref_rf [16];
  logic [DW-1:0] ref_sm [4096];
  logic [DW-1:0] tb_sm  [4096];
  bit            exp_we [$];
  int            exp_addr [$], exp_wd [$], dly_q [$];
  logic [15:0]   prog [$];
  int            fix_dly = -1, exp_cycles, cyc;
  bit            exp_div, abort_flag = 0;
  int            last_addr, last_wd;

  // Instruction-level execution of prog[0..len-1] against ref_rf/ref_sm.
  task automatic model(input int len);
    int pc, npc, steps, a, b, rd, addr, res, mask, k;
    logic [15:0] ir;
    logic [3:0]  op;
    bit wr, fin;
    mask = (1 << DW) - 1;
    pc = 0; steps = 0; fin = 0; exp_div = 0; exp_cycles = 0;
    while (!fin && steps < 500) begin
      ir = prog[pc]; op = ir[15:12];
      a = ref_rf[ir[11:8]]; b = ref_rf[ir[7:4]]; rd = int'(ir[3:0]);
      addr = (((b & 15) << DW) | a) & ((1 << AW) - 1);
      npc = pc + 1; wr = 1; res = 0; exp_cycles += 5;
      case (op)
        4'd0:  begin wr = (ir[11:4] == 8'h01); res = CID & mask; end
        4'd1:  res = (a + b) & mask;
        4'd2:  res = (a - b) & mask;
        4'd3:  res = (a * b) & mask;
        4'd4:  if (b == 0) begin res = mask; exp_div = 1; end else res = a / b;
        4'd5:  res = (a >= b) ? 1 : 0;
        4'd6:  res = ((b & 15) >= DW) ? 0 : (a >> (b & 15));
        4'd7:  res = ((b & 15) >= DW) ? 0 : ((a << (b & 15)) & mask);
        4'd8:  res = a & b;
        4'd9:  res = a | b;
        4'd10: res = a ^ b;
        4'd11: begin
          k = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
          dly_q.push_back(k); exp_cycles += 1 + k;
          exp_we.push_back(0); exp_addr.push_back(addr); exp_wd.push_back(0);
          res = int'(ref_sm[addr]);
        end
        4'd12: res = int'(ir[11:4]) & mask;
        4'd13: begin
          wr = 0;
          k = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
          dly_q.push_back(k); exp_cycles += 1 + k;
          exp_we.push_back(1); exp_addr.push_back(addr); exp_wd.push_back(ref_rf[rd]);
          ref_sm[addr] = DW'(ref_rf[rd]);
        end
        4'd14: begin wr = 0; if (a != 0) npc = int'(ir[7:4]) % DEPTH; end
        default: begin wr = 0; fin = 1; end
      endcase
      if (wr) ref_rf[rd] = res;
      if (npc >= len) fin = 1;
      pc = npc; steps++;
    end
  endtask

  // Shared-memory responder and request monitor.
  int cur_dly = 0, cnt = 0;
  bit seen = 0;
  logic [AW+DW:0] hold_s;
  always @(negedge clk) begin
    if (mem_req) begin
      if (!seen) begin
        seen = 1; cnt = 0; hold_s = {mem_we, mem_addr, mem_wdata};
        cur_dly = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
        last_addr = int'(mem_addr); last_wd = int'(mem_wdata);
        if (exp_we.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          chk("req_we", mem_we, exp_we.pop_front());
          chk("req_addr", mem_addr, exp_addr.pop_front());
          if (mem_we) chk("req_wdata", mem_wdata, exp_wd.pop_front());
          else void'(exp_wd.pop_front());
        end
      end else begin
        chk("mem_hold", {mem_we, mem_addr, mem_wdata}, hold_s);
      end
      mem_ack = (cnt == cur_dly);
      if (mem_ack) begin
        if (mem_we) tb_sm[mem_addr] = mem_wdata;
        else mem_rdata = tb_sm[mem_addr];
      end
      cnt++;
    end else begin
      if (seen && !abort_flag) chk("req_len", cnt, cur_dly + 1);
      seen = 0;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = DW'($urandom);
    end
  end

  task automatic load_words(input int n, input bit use_last, input bit extra);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rtr_load", rtr, 1);
      if (i == 1) chk("ready_clr", ready, 0);
      val_ins = 1; instruction = prog[i]; ins_last = use_last && (i == n - 1);
    end
    @(negedge clk);
    val_ins = extra; instruction = 16'hD0F0; ins_last = extra;
    chk("rtr_fetch", rtr, 0);
  endtask

  task automatic run_prog(input int n, input bit use_last, input bit extra);
    model(n);
    load_words(n, use_last, extra);
    cyc = 0;
    while (!ready && cyc < 3000) begin
      @(negedge clk);
      val_ins = 0; ins_last = 0;
      cyc++;
    end
    chk("done_ready", ready, 1);
    chk("cycles", cyc, exp_cycles);
    chk("div_err", div_err, exp_div);
    chk("rtr_done", rtr, 1);
    @(negedge clk);
    chk("ready_hold", ready, 1);
    chk("exp_empty", exp_we.size(), 0);
  endtask

  initial begin
    int n, tmo;
    logic [3:0] op;
    logic [15:0] w;
    for (int a = 0; a < 4096; a++) begin
      tb_sm[a] = DW'(a * 7 + 3); ref_sm[a] = DW'(a * 7 + 3);
    end
    for (int r = 0; r < 16; r++) ref_rf[r] = 0;

    #12;
    chk("rst_rtr", rtr, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ready", ready, 0);
    chk("rst_diverr", div_err, 0);
    @(negedge clk); reset_n = 1;

    prog = '{16'hC051, 16'hC032, 16'h1123, 16'hD003, 16'hF000};
    run_prog(5, 1, 0);
    chk("t1_addr", last_addr, 0);
    chk("t1_wdata", last_wd, 8'h08);

    prog = '{16'hC071, 16'h4102};
    run_prog(2, 1, 0);
    chk("t2_diverr", div_err, 1);
    prog = '{16'hD002, 16'hF000};
    run_prog(2, 1, 0);
    chk("t2_r2", last_wd, 8'hFF);
    chk("t2_diverr_clr", div_err, 0);

    prog = '{16'hC031, 16'hC012, 16'h2121, 16'hE120};
    run_prog(4, 1, 0);
    chk("t3_cycles", cyc, 40);
    prog = '{16'hD001, 16'hF000};
    run_prog(2, 1, 0);
    chk("t3_r1", last_wd, 0);

    fix_dly = 3; tb_sm[12'hA00] = 8'h5C; ref_sm[12'hA00] = 8'h5C;
    prog = '{16'hC0A1, 16'hC002, 16'hB012};
    run_prog(3, 1, 0);
    fix_dly = -1;
    chk("t4_addr", last_addr, 12'hA00);
    prog = '{16'hD002, 16'hF000};
    run_prog(2, 1, 0);
    chk("t4_r2", last_wd, 8'h5C);

    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back({4'hC, 8'($urandom), 4'($urandom)});
    run_prog(16, 0, 1);

    abort_flag = 1; fix_dly = 1000;
    prog = '{16'hC0A1, 16'hC002, 16'hB012};
    model(3);
    load_words(3, 1, 0);
    val_ins = 0; ins_last = 0;
    tmo = 0;
    while (!mem_req && tmo < 100) begin @(negedge clk); tmo++; end
    chk("rst_mw_req", mem_req, 1);
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("rst_mw_req_drop", mem_req, 0);
    chk("rst_mw_rtr", rtr, 1);
    chk("rst_mw_ready", ready, 0);
    @(negedge clk); reset_n = 1;
    for (int r = 0; r < 16; r++) ref_rf[r] = 0;
    exp_we.delete(); exp_addr.delete(); exp_wd.delete(); dly_q.delete();
    fix_dly = -1;
    repeat (2) @(negedge clk);
    abort_flag = 0;
    prog = '{16'hD001, 16'hD002, 16'hF000};
    run_prog(3, 1, 0);
    chk("rst_rf_clr", last_wd, 0);

    for (int t = 0; t < 12; t++) begin
      n = int'($urandom_range(3, 16));
      prog.delete();
      for (int i = 0; i < n; i++) begin
        op = 4'($urandom);
        w = {op, 12'($urandom)};
        if (op == 4'd0 && $urandom_range(0, 1) == 1) w[11:4] = 8'h01;
        if (op == 4'd14) begin
          if (i < 15) w[7:4] = 4'($urandom_range(i + 1, 15));
          else w = 16'hF000;
        end
        prog.push_back(w);
      end
      run_prog(n, 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
